// File: rtl/obi_result_fifo_responder.sv
// obi_result_fifo_responder
// OBI subordinate that collects result words from the core into a
// show-ahead FIFO drained by host-side register logic. A word offset
// map (addr[3:2]) exposes DATA, STATUS and CTRL registers.
// Optional build macro OBI_RESP_ERR_EN adds an err_o response flag for
// accesses to the unmapped offset and for writes to STATUS.

module obi_result_fifo_responder #(
  parameter int pDEPTH = 8,
  parameter int pDW    = 32,
  parameter int pAW    = 32
) (
  input  logic                       clk,
  input  logic                       reset_i,
  input  logic                       req_i,
  input  logic                       we_i,
  input  logic [3:0]                 be_i,
  input  logic [pAW-1:0]             addr_i,
  input  logic [pDW-1:0]             wdata_i,
  output logic                       gnt_o,
  output logic                       rvalid_o,
  output logic [pDW-1:0]             rdata_o,
  input  logic                       pop_i,
  output logic [pDW-1:0]             pop_data_o,
  output logic                       empty_o,
  output logic [$clog2(pDEPTH):0]    count_o
`ifdef OBI_RESP_ERR_EN
  ,
  output logic                       err_o
`endif
);

  localparam int pPW = $clog2(pDEPTH);
  localparam int pCW = pPW + 1;
  localparam logic [pCW-1:0] cFullCount = pCW'(pDEPTH);

  localparam logic [1:0] cOffData   = 2'd0;
  localparam logic [1:0] cOffStatus = 2'd1;
  localparam logic [1:0] cOffCtrl   = 2'd2;

  // FIFO storage and bookkeeping
  logic [pDW-1:0] r_mem [pDEPTH];
  logic [pPW-1:0] r_wrPtr;
  logic [pPW-1:0] r_rdPtr;
  logic [pCW-1:0] r_count;
  logic           r_underflow;
  logic [pDW-1:0] r_lastWord;

  // Response registers
  logic           r_rvalid;
  logic [pDW-1:0] r_rdata;
`ifdef OBI_RESP_ERR_EN
  logic           r_err;
`endif

  logic [1:0]     w_off;
  logic           w_empty;
  logic           w_full;
  logic           w_popEff;
  logic           w_xfer;
  logic           w_push;
  logic           w_flush;
  logic           w_clrUf;
  logic           w_ufEvent;
  logic [pDW-1:0] w_pushWord;
  logic [pDW-1:0] w_status;
  logic [pDW-1:0] w_readData;
  logic           w_unusedAddr;

  assign w_off     = addr_i[3:2];
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == cFullCount);
  assign w_popEff  = pop_i & ~w_empty;

  // A DATA write into a full FIFO waits unless the host frees a slot this cycle
  assign gnt_o     = req_i & ~(we_i & (w_off == cOffData) & w_full & ~w_popEff);
  assign w_xfer    = req_i & gnt_o;

  assign w_push    = w_xfer & we_i & (w_off == cOffData);
  assign w_flush   = w_xfer & we_i & (w_off == cOffCtrl) & wdata_i[0];
  assign w_clrUf   = w_xfer & we_i & (w_off == cOffCtrl) & wdata_i[1];
  assign w_ufEvent = pop_i & w_empty & ~w_flush;

  assign w_unusedAddr = ^{addr_i[pAW-1:4], addr_i[1:0]};

  // Build the pushed word: disabled byte lanes are forced to zero
  always_comb begin
    w_pushWord = '0;
    for (int k = 0; k < pDW / 8; k++) begin
      w_pushWord[8*k +: 8] = be_i[k] ? wdata_i[8*k +: 8] : 8'h00;
    end
  end

  // Assemble STATUS and select the read value for the addressed register
  always_comb begin
    w_status             = '0;
    w_status[0]          = w_empty;
    w_status[1]          = w_full;
    w_status[2]          = r_underflow;
    w_status[16 +: pCW]  = r_count;
    w_readData = '0;
    case (w_off)
      cOffData:   w_readData = r_lastWord;
      cOffStatus: w_readData = w_status;
      default:    w_readData = '0;
    endcase
  end

  // Storage array needs no reset; empty FIFO output is masked below
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= w_pushWord;
    end
  end

  // Pointer and occupancy update; a flush overrides any push or pop this cycle
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + pPW'(1);
      end
      if (w_popEff) begin
        r_rdPtr <= r_rdPtr + pPW'(1);
      end
      if (w_push && !w_popEff) begin
        r_count <= r_count + pCW'(1);
      end else if (!w_push && w_popEff) begin
        r_count <= r_count - pCW'(1);
      end
    end
  end

  // Sticky underflow flag; a new underflow beats a same-cycle clear
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_underflow <= 1'b0;
    end else if (w_ufEvent) begin
      r_underflow <= 1'b1;
    end else if (w_clrUf) begin
      r_underflow <= 1'b0;
    end
  end

  // Remember the most recently pushed word for DATA readback
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_lastWord <= '0;
    end else if (w_push) begin
      r_lastWord <= w_pushWord;
    end
  end

  // One-cycle response for every granted transaction; data only for reads
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_xfer;
      r_rdata  <= (w_xfer && !we_i) ? w_readData : '0;
    end
  end

`ifdef OBI_RESP_ERR_EN
  // Flag accesses to the unmapped offset and writes to read-only STATUS
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_xfer & ((w_off == 2'd3) | (we_i & (w_off == cOffStatus)));
    end
  end

  assign err_o = r_err;
`endif

  assign rvalid_o   = r_rvalid;
  assign rdata_o    = r_rdata;
  assign pop_data_o = w_empty ? '0 : r_mem[r_rdPtr];
  assign empty_o    = w_empty;
  assign count_o    = r_count;

endmodule

// File: tb/tb_obi_result_fifo_responder.sv
// tb_obi_result_fifo_responder
// Table of single OBI transactions with expected response data and FIFO
// state, plus hand-written sequences for back-to-back fill, full stall,
// wrap-around drain and reset with a response in flight. Every granted
// transaction pushes its expected rdata to a queue that is matched
// against rvalid_o/rdata_o. Optional macro OBI_RESP_ERR_EN enables the
// err_o checks.

module tb_obi_result_fifo_responder;

  logic        clk;
  logic        reset_i;
  logic        req_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        pop_i;
  logic [31:0] pop_data_o;
  logic        empty_o;
  logic [3:0]  count_o;
`ifdef OBI_RESP_ERR_EN
  logic        err_o;
`endif

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        pop;
    logic [31:0] expRdata;
    logic [3:0]  expCount;
    logic [31:0] expHead;
    logic        expEmpty;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] respQ[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] tbExpData = '0;
  logic [31:0] tbExpNext = '0;
  logic        tbGrantNext = 1'b0;

  obi_result_fifo_responder #(
    .pDEPTH(8),
    .pDW(32),
    .pAW(32)
  ) dut (
    .clk(clk),
    .reset_i(reset_i),
    .req_i(req_i),
    .we_i(we_i),
    .be_i(be_i),
    .addr_i(addr_i),
    .wdata_i(wdata_i),
    .gnt_o(gnt_o),
    .rvalid_o(rvalid_o),
    .rdata_o(rdata_o),
    .pop_i(pop_i),
    .pop_data_o(pop_data_o),
    .empty_o(empty_o),
    .count_o(count_o)
`ifdef OBI_RESP_ERR_EN
    ,
    .err_o(err_o)
`endif
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a stuck design still ends the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Response monitor: match responses against the scoreboard, then note this cycle's grant
  always @(negedge clk) begin
    if (respQ.size() != 0) begin
      logic [31:0] expR;
      expR = respQ.pop_front();
      checkOutput("resp_rvalid", {31'b0, rvalid_o}, 32'd1);
      checkOutput("resp_rdata", rdata_o, expR);
    end else begin
      checkOutput("idle_rvalid", {31'b0, rvalid_o}, 32'd0);
      checkOutput("idle_rdata", rdata_o, 32'd0);
    end
    tbGrantNext = req_i & gnt_o;
    tbExpNext   = tbExpData;
  end

  // Scoreboard push at the granting edge
  always @(posedge clk) begin
    if (tbGrantNext && !reset_i) begin
      respQ.push_back(tbExpNext);
    end
  end

  task automatic addVec(input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d, input logic p, input logic [31:0] r,
                        input logic [3:0] c, input logic [31:0] h, input logic e);
    vec_t v;
    v.we = w; v.be = b; v.addr = a; v.wdata = d; v.pop = p;
    v.expRdata = r; v.expCount = c; v.expHead = h; v.expEmpty = e;
    vecs.push_back(v);
  endtask

  // Drive one transaction (with optional same-cycle pop) and wait for its grant
  task automatic applyStimulus(input logic w, input logic [3:0] b, input logic [31:0] a,
                               input logic [31:0] d, input logic p, input logic [31:0] r);
    logic granted;
    granted = 1'b0;
    @(posedge clk);
    #1;
    req_i = 1'b1; we_i = w; be_i = b; addr_i = a; wdata_i = d; pop_i = p;
    tbExpData = r;
    for (int i = 0; i < 20 && !granted; i++) begin
      @(negedge clk);
      granted = gnt_o;
      @(posedge clk);
    end
    #1;
    req_i = 1'b0; we_i = 1'b0; pop_i = 1'b0; be_i = 4'h0; addr_i = '0; wdata_i = '0;
    if (!granted) begin
      total++;
      bad++;
      $display("[TB] FAIL grant_timeout actual=no_grant required=grant");
    end
  endtask

  task automatic hostPop();
    @(posedge clk);
    #1 pop_i = 1'b1;
    @(posedge clk);
    #1 pop_i = 1'b0;
  endtask

  task automatic checkFifo(input string tag, input logic [3:0] c, input logic [31:0] h, input logic e);
    checkOutput({tag, "_count"}, {28'b0, count_o}, {28'b0, c});
    checkOutput({tag, "_head"}, pop_data_o, h);
    checkOutput({tag, "_empty"}, {31'b0, empty_o}, {31'b0, e});
  endtask

  initial begin
    reset_i = 1'b1;
    req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = '0; wdata_i = '0; pop_i = 1'b0;

    // Reset values
    #3;
    checkOutput("rst_gnt", {31'b0, gnt_o}, 32'd0);
    checkOutput("rst_rvalid", {31'b0, rvalid_o}, 32'd0);
    checkOutput("rst_rdata", rdata_o, 32'd0);
    checkFifo("rst", 4'd0, 32'd0, 1'b1);
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;

    // we, be, addr, wdata, pop, expRdata, expCount, expHead, expEmpty
    addVec(1, 4'hF, 32'h0, 32'h11223344, 0, 32'h0,        4'd1, 32'h11223344, 0);
    addVec(1, 4'h5, 32'h0, 32'hAABBCCDD, 0, 32'h0,        4'd2, 32'h11223344, 0);
    addVec(0, 4'hF, 32'h0, 32'h0,        0, 32'h00BB00DD, 4'd2, 32'h11223344, 0);
    addVec(0, 4'hF, 32'h4, 32'h0,        0, 32'h00020000, 4'd2, 32'h11223344, 0);
    addVec(1, 4'h0, 32'h0, 32'hDEADBEEF, 1, 32'h0,        4'd2, 32'h00BB00DD, 0);
    addVec(0, 4'hF, 32'h0, 32'h0,        0, 32'h0,        4'd2, 32'h00BB00DD, 0);
    addVec(0, 4'hF, 32'h8, 32'h0,        0, 32'h0,        4'd2, 32'h00BB00DD, 0);
    addVec(0, 4'hF, 32'hC, 32'h0,        0, 32'h0,        4'd2, 32'h00BB00DD, 0);
    addVec(1, 4'hF, 32'h4, 32'hFFFFFFFF, 0, 32'h0,        4'd2, 32'h00BB00DD, 0);
    addVec(1, 4'hF, 32'hC, 32'h3,        0, 32'h0,        4'd2, 32'h00BB00DD, 0);
    addVec(0, 4'hF, 32'h0, 32'h0,        1, 32'h0,        4'd1, 32'h0,        0);
    addVec(0, 4'hF, 32'h0, 32'h0,        1, 32'h0,        4'd0, 32'h0,        1);
    addVec(0, 4'hF, 32'h4, 32'h0,        1, 32'h00000001, 4'd0, 32'h0,        1);
    addVec(0, 4'hF, 32'h4, 32'h0,        0, 32'h00000005, 4'd0, 32'h0,        1);
    addVec(1, 4'hF, 32'h8, 32'h2,        0, 32'h0,        4'd0, 32'h0,        1);
    addVec(0, 4'hF, 32'h4, 32'h0,        0, 32'h00000001, 4'd0, 32'h0,        1);
    addVec(1, 4'hF, 32'h0, 32'h12345678, 1, 32'h0,        4'd1, 32'h12345678, 0);
    addVec(0, 4'hF, 32'h4, 32'h0,        0, 32'h00010004, 4'd1, 32'h12345678, 0);
    addVec(1, 4'hF, 32'h8, 32'h2,        1, 32'h0,        4'd0, 32'h0,        1);
    addVec(0, 4'hF, 32'h4, 32'h0,        1, 32'h00000001, 4'd0, 32'h0,        1);
    addVec(1, 4'hF, 32'h8, 32'h2,        1, 32'h0,        4'd0, 32'h0,        1);
    addVec(0, 4'hF, 32'h4, 32'h0,        0, 32'h00000005, 4'd0, 32'h0,        1);
    addVec(1, 4'hF, 32'h8, 32'h2,        0, 32'h0,        4'd0, 32'h0,        1);
    addVec(1, 4'hF, 32'h0, 32'hA1,       0, 32'h0,        4'd1, 32'hA1,       0);
    addVec(1, 4'hF, 32'h0, 32'hA2,       0, 32'h0,        4'd2, 32'hA1,       0);
    addVec(1, 4'hF, 32'h0, 32'hA3,       0, 32'h0,        4'd3, 32'hA1,       0);
    addVec(1, 4'hF, 32'h8, 32'h1,        1, 32'h0,        4'd0, 32'h0,        1);
    addVec(0, 4'hF, 32'h4, 32'h0,        0, 32'h00000001, 4'd0, 32'h0,        1);
    addVec(1, 4'hF, 32'h8, 32'h3,        1, 32'h0,        4'd0, 32'h0,        1);
    addVec(0, 4'hF, 32'h4, 32'h0,        0, 32'h00000001, 4'd0, 32'h0,        1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, vecs[i].pop, vecs[i].expRdata);
      checkFifo($sformatf("v%0d", i), vecs[i].expCount, vecs[i].expHead, vecs[i].expEmpty);
    end

    // Back-to-back fill of all 8 entries, one grant per cycle
    @(posedge clk);
    #1;
    req_i = 1'b1; we_i = 1'b1; be_i = 4'hF; addr_i = 32'h0; tbExpData = 32'h0;
    for (int i = 0; i < 8; i++) begin
      wdata_i = 32'h100 + i;
      @(negedge clk);
      checkOutput($sformatf("fill%0d_gnt", i), {31'b0, gnt_o}, 32'd1);
      @(posedge clk);
      #1;
    end
    req_i = 1'b0; we_i = 1'b0;
    checkFifo("full", 4'd8, 32'h100, 1'b0);
    applyStimulus(0, 4'hF, 32'h4, 32'h0, 0, 32'h00080002);

    // Ninth write stalls while full, then is granted in the cycle the host pops
    @(posedge clk);
    #1;
    req_i = 1'b1; we_i = 1'b1; be_i = 4'hF; addr_i = 32'h0; wdata_i = 32'h200; tbExpData = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("stall%0d_gnt", i), {31'b0, gnt_o}, 32'd0);
    end
    @(posedge clk);
    #1 pop_i = 1'b1;
    @(negedge clk);
    checkOutput("release_gnt", {31'b0, gnt_o}, 32'd1);
    @(posedge clk);
    #1;
    req_i = 1'b0; we_i = 1'b0; pop_i = 1'b0;
    checkFifo("after_release", 4'd8, 32'h101, 1'b0);

    // Drain across the pointer wrap
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("drain%0d_head", i), pop_data_o, (i < 7) ? (32'h101 + i) : 32'h200);
      hostPop();
    end
    checkFifo("drained", 4'd0, 32'h0, 1'b1);

    // Build up state, then reset with a read response in flight
    hostPop();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 4'hF, 32'h0, 32'h300 + i, 0, 32'h0);
    end
    checkFifo("pre_reset", 4'd5, 32'h300, 1'b0);
    applyStimulus(0, 4'hF, 32'h4, 32'h0, 0, 32'h00050004);
    #1;
    reset_i = 1'b1;
    tbGrantNext = 1'b0;
    respQ.delete();
    #1;
    checkOutput("mid_rst_rvalid", {31'b0, rvalid_o}, 32'd0);
    checkOutput("mid_rst_rdata", rdata_o, 32'd0);
    checkOutput("mid_rst_gnt", {31'b0, gnt_o}, 32'd0);
    checkFifo("mid_rst", 4'd0, 32'h0, 1'b1);
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;

    // Reset cleared sticky flag and last-word register
    applyStimulus(0, 4'hF, 32'h4, 32'h0, 0, 32'h00000001);
    applyStimulus(0, 4'hF, 32'h0, 32'h0, 0, 32'h0);
    applyStimulus(1, 4'hF, 32'h0, 32'hCAFEF00D, 0, 32'h0);
    checkFifo("post_rst", 4'd1, 32'hCAFEF00D, 1'b0);
    applyStimulus(0, 4'hF, 32'h0, 32'h0, 0, 32'hCAFEF00D);

`ifdef OBI_RESP_ERR_EN
    applyStimulus(0, 4'hF, 32'hC, 32'h0, 0, 32'h0);
    checkOutput("err_unmapped", {31'b0, err_o}, 32'd1);
    applyStimulus(0, 4'hF, 32'h4, 32'h0, 0, 32'h00010000);
    checkOutput("err_status_rd", {31'b0, err_o}, 32'd0);
    applyStimulus(1, 4'hF, 32'h4, 32'h0, 0, 32'h0);
    checkOutput("err_status_wr", {31'b0, err_o}, 32'd1);
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
